qdiv_stream: RTL and testbench

//  Streaming signed fixed-point divider, successor to the single-shot fixed-point divider.

---
 rtl/qdiv_stream.sv | 191 +++++++++++++++++++
 tb/tb_qdiv_stream.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/qdiv_stream.sv
// Purpose: streaming signed Q-format divider, quotient = (dividend << Q) / divisor, R quotient bits per cycle.
// Latency: ceil((N+Q)/R)+1 edges from accept to o_valid; a zero divisor answers after 1 edge.
// Backpressure: single entry, o_ready only in IDLE, result held until i_ready. Option QDIV_SAT_EN saturates overflow/dbz.
module qdiv_stream #(
   parameter int N = 16,
   parameter int Q = 8,
   parameter int R = 1
)(
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_valid,
   output logic         o_ready,
   input  logic [N-1:0] i_dividend,
   input  logic [N-1:0] i_divisor,
   output logic         o_valid,
   input  logic         i_ready,
   output logic [N-1:0] o_quotient,
   output logic         o_overflow,
   output logic         o_dbz
);

   // Steps needed to cover the N+Q-bit shifted dividend; W pads it up to a whole number of steps.
   localparam int ITER = (N + Q + R - 1) / R;
   localparam int W    = ITER * R;
   localparam int CW   = $clog2(ITER + 1);

   // Largest representable magnitudes for positive and negative results, widened to the full quotient.
   localparam logic [W-1:0] MAX_POS = {{(W-N+1){1'b0}}, {(N-1){1'b1}}};
   localparam logic [W-1:0] MAX_NEG = {{(W-N){1'b0}}, 1'b1, {(N-1){1'b0}}};

`ifdef QDIV_SAT_EN
   localparam logic [N-1:0] SAT_POS = {1'b0, {(N-1){1'b1}}};
   localparam logic [N-1:0] SAT_NEG = {1'b1, {(N-1){1'b0}}};
`endif

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          state_q;
   state_t          state_d;

   logic            accept;
   logic            div_zero;
   logic            last_step;

   logic [N-1:0]    dvd_mag;
   logic [N-1:0]    dvs_mag;
   logic [W-1:0]    dvd_init;
   logic [N-1:0]    dbz_result;

   logic            sign_q;
   logic [N-1:0]    dvs_q;
   logic [N:0]      rem_q;
   logic [W-1:0]    dvd_q;
   logic [W-1:0]    quo_q;
   logic [CW-1:0]   cnt_q;

   logic [N:0]      rem_n;
   logic [W-1:0]    dvd_n;
   logic [W-1:0]    quo_n;

   logic [N-1:0]    quo_lo;
   logic            ovf_n;
   logic [N-1:0]    res_n;

   assign accept    = i_valid && o_ready;
   assign div_zero  = (i_divisor == '0);
   assign last_step = (cnt_q == CW'(1));

   // Operand magnitudes as unsigned N-bit values, so the most negative input keeps its full magnitude.
   always_comb begin
      dvd_mag  = i_dividend[N-1] ? -i_dividend : i_dividend;
      dvs_mag  = i_divisor[N-1]  ? -i_divisor  : i_divisor;
      dvd_init = '0;
      dvd_init[N+Q-1:Q] = dvd_mag;
`ifdef QDIV_SAT_EN
      dbz_result = i_dividend[N-1] ? SAT_NEG : SAT_POS;
`else
      dbz_result = '0;
`endif
   end

   // State register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and handshake outputs; o_ready and o_valid come from disjoint states so never overlap.
   always_comb begin
      state_d = state_q;
      o_ready = 1'b0;
      o_valid = 1'b0;
      case (state_q)
         S_IDLE: begin
            o_ready = 1'b1;
            if (i_valid) begin
               state_d = div_zero ? S_DONE : S_CALC;
            end
         end
         S_CALC: begin
            if (last_step) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            o_valid = 1'b1;
            if (i_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // R restoring-division steps per cycle, MSB first: shift in a dividend bit, subtract if it fits.
   always_comb begin
      rem_n = rem_q;
      dvd_n = dvd_q;
      quo_n = quo_q;
      for (int j = 0; j < R; j++) begin
         rem_n = {rem_n[N-1:0], dvd_n[W-1]};
         dvd_n = {dvd_n[W-2:0], 1'b0};
         if (rem_n >= {1'b0, dvs_q}) begin
            rem_n = rem_n - {1'b0, dvs_q};
            quo_n = {quo_n[W-2:0], 1'b1};
         end else begin
            quo_n = {quo_n[W-2:0], 1'b0};
         end
      end
   end

   // Apply sign and range to the final magnitude; the overflow compare spans every quotient bit.
   always_comb begin
      ovf_n  = sign_q ? (quo_n > MAX_NEG) : (quo_n > MAX_POS);
      quo_lo = quo_n[N-1:0];
      // Negating the low N bits equals the low N bits of the negated quotient; zero stays zero.
      res_n  = sign_q ? -quo_lo : quo_lo;
`ifdef QDIV_SAT_EN
      if (ovf_n) begin
         res_n = sign_q ? SAT_NEG : SAT_POS;
      end
`endif
   end

   // Datapath: load on accept, iterate in CALC, publish the result on the last step and hold it in DONE.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sign_q     <= 1'b0;
         dvs_q      <= '0;
         rem_q      <= '0;
         dvd_q      <= '0;
         quo_q      <= '0;
         cnt_q      <= '0;
         o_quotient <= '0;
         o_overflow <= 1'b0;
         o_dbz      <= 1'b0;
      end else if (accept) begin
         sign_q     <= i_dividend[N-1] ^ i_divisor[N-1];
         dvs_q      <= dvs_mag;
         rem_q      <= '0;
         dvd_q      <= dvd_init;
         quo_q      <= '0;
         cnt_q      <= CW'(ITER);
         o_overflow <= 1'b0;
         o_dbz      <= div_zero;
         // A zero divisor skips CALC, so its answer has to be in place by the next edge.
         if (div_zero) begin
            o_quotient <= dbz_result;
         end
      end else if (state_q == S_CALC) begin
         rem_q <= rem_n;
         dvd_q <= dvd_n;
         quo_q <= quo_n;
         cnt_q <= cnt_q - CW'(1);
         if (last_step) begin
            o_quotient <= res_n;
            o_overflow <= ovf_n;
         end
      end
   end

endmodule

// File: tb/tb_qdiv_stream.sv
// Directed bench for qdiv_stream: an R=1 and an R=4 instance share operands, selected by sel4.
// Each transaction checks latency, result, flags and the handshake around the handoff.
// Expected results are hand-computed Q8.8 quotients; the QDIV_SAT_EN build changes only the saturating cases.
module tb_qdiv_stream;
   localparam int N = 16;

   logic         i_clk = 1'b0;
   logic         i_rst_n;
   logic         in_vld;
   logic         in_rdy;
   logic         sel4;
   logic [N-1:0] dividend;
   logic [N-1:0] divisor;

   logic         vld1_i, rdy1_i, rdy1_o, vld1_o, ovf1, dbz1;
   logic         vld4_i, rdy4_i, rdy4_o, vld4_o, ovf4, dbz4;
   logic [N-1:0] quo1, quo4;

   logic         v_rdy, v_vld, v_ovf, v_dbz;
   logic [N-1:0] v_quo;

   int n_checks = 0;
   int n_errors = 0;

   always #5 i_clk = ~i_clk;

   assign vld1_i = in_vld & ~sel4;
   assign vld4_i = in_vld &  sel4;
   assign rdy1_i = in_rdy & ~sel4;
   assign rdy4_i = in_rdy &  sel4;

   assign v_rdy = sel4 ? rdy4_o : rdy1_o;
   assign v_vld = sel4 ? vld4_o : vld1_o;
   assign v_quo = sel4 ? quo4   : quo1;
   assign v_ovf = sel4 ? ovf4   : ovf1;
   assign v_dbz = sel4 ? dbz4   : dbz1;

   qdiv_stream #(.N(16), .Q(8), .R(1)) dut1 (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_valid    (vld1_i),
      .o_ready    (rdy1_o),
      .i_dividend (dividend),
      .i_divisor  (divisor),
      .o_valid    (vld1_o),
      .i_ready    (rdy1_i),
      .o_quotient (quo1),
      .o_overflow (ovf1),
      .o_dbz      (dbz1)
   );

   qdiv_stream #(.N(16), .Q(8), .R(4)) dut4 (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_valid    (vld4_i),
      .o_ready    (rdy4_o),
      .i_dividend (dividend),
      .i_divisor  (divisor),
      .o_valid    (vld4_o),
      .i_ready    (rdy4_i),
      .o_quotient (quo4),
      .o_overflow (ovf4),
      .o_dbz      (dbz4)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One transaction; operands change and i_valid stays high while busy to prove they are ignored.
   task automatic run_div(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [N-1:0] exp_q, input logic exp_ovf, input logic exp_dbz,
                          input int exp_lat, input int hold);
      int lat;
      logic [N-1:0] held_q;
      check({tag, "_rdy_idle"}, 32'(v_rdy), 32'd1);
      check({tag, "_vld_idle"}, 32'(v_vld), 32'd0);
      dividend = a;
      divisor  = b;
      in_vld   = 1'b1;
      @(posedge i_clk); #1;
      dividend = 16'h1234;
      divisor  = 16'h0001;
      lat = 1;
      check({tag, "_rdy_busy"}, 32'(v_rdy), 32'd0);
      while (!v_vld && lat < 200) begin
         @(posedge i_clk); #1;
         lat++;
      end
      in_vld = 1'b0;
      check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      check({tag, "_quo"}, 32'(v_quo), 32'(exp_q));
      check({tag, "_ovf"}, 32'(v_ovf), 32'(exp_ovf));
      check({tag, "_dbz"}, 32'(v_dbz), 32'(exp_dbz));
      held_q = exp_q;
      for (int i = 0; i < hold; i++) begin
         @(posedge i_clk); #1;
         check({tag, "_hold_vld"}, 32'(v_vld), 32'd1);
         check({tag, "_hold_rdy"}, 32'(v_rdy), 32'd0);
         check({tag, "_hold_quo"}, 32'(v_quo), 32'(held_q));
      end
      in_rdy = 1'b1;
      @(posedge i_clk); #1;
      in_rdy = 1'b0;
      check({tag, "_vld_after"}, 32'(v_vld), 32'd0);
      check({tag, "_rdy_after"}, 32'(v_rdy), 32'd1);
   endtask

   initial begin
      logic [N-1:0] ovf_q;
      logic [N-1:0] dbz_pos_q;
      logic [N-1:0] dbz_neg_q;
`ifdef QDIV_SAT_EN
      ovf_q     = 16'h7FFF;
      dbz_pos_q = 16'h7FFF;
      dbz_neg_q = 16'h8000;
`else
      ovf_q     = 16'h8000;
      dbz_pos_q = 16'h0000;
      dbz_neg_q = 16'h0000;
`endif
      i_rst_n  = 1'b0;
      in_vld   = 1'b0;
      in_rdy   = 1'b0;
      sel4     = 1'b0;
      dividend = '0;
      divisor  = '0;
      #2;
      check("reset_rdy",  32'(rdy1_o), 32'd1);
      check("reset_vld",  32'(vld1_o), 32'd0);
      check("reset_quo",  32'(quo1),   32'd0);
      check("reset_ovf",  32'(ovf1),   32'd0);
      check("reset_dbz",  32'(dbz1),   32'd0);
      check("reset_rdy4", 32'(rdy4_o), 32'd1);
      #20;
      i_rst_n = 1'b1;
      @(posedge i_clk); #1;

      // R=1: 1.5, -1.5, 1/3, -1/3, overflow, divide-by-zero both signs, then flags clear on accept.
      run_div("c1_pos",   16'h0300, 16'h0200, 16'h0180, 1'b0, 1'b0, 25, 0);
      run_div("c2_neg",   16'hFD00, 16'h0200, 16'hFE80, 1'b0, 1'b0, 25, 0);
      run_div("c3_third", 16'h0100, 16'h0300, 16'h0055, 1'b0, 1'b0, 25, 0);
      run_div("c4_nthird",16'hFF00, 16'h0300, 16'hFFAB, 1'b0, 1'b0, 25, 0);
      run_div("c5_ovf",   16'h8000, 16'hFF00, ovf_q,    1'b1, 1'b0, 25, 0);
      run_div("c6_dbz",   16'h0100, 16'h0000, dbz_pos_q,1'b0, 1'b1, 1,  0);
      run_div("c7_ndbz",  16'hFF00, 16'h0000, dbz_neg_q,1'b0, 1'b1, 1,  0);
      run_div("c8_zero",  16'h0000, 16'hFF00, 16'h0000, 1'b0, 1'b0, 25, 0);
      run_div("c9_hold",  16'h0300, 16'h0200, 16'h0180, 1'b0, 1'b0, 25, 10);

      // Reset in the seventh CALC cycle must drop everything back to reset values at once.
      dividend = 16'h0100;
      divisor  = 16'h0300;
      in_vld   = 1'b1;
      @(posedge i_clk); #1;
      in_vld = 1'b0;
      repeat (6) @(posedge i_clk);
      #2;
      i_rst_n = 1'b0;
      #1;
      check("mid_rst_rdy", 32'(rdy1_o), 32'd1);
      check("mid_rst_vld", 32'(vld1_o), 32'd0);
      check("mid_rst_quo", 32'(quo1),   32'd0);
      check("mid_rst_ovf", 32'(ovf1),   32'd0);
      check("mid_rst_dbz", 32'(dbz1),   32'd0);
      @(posedge i_clk); #2;
      check("mid_rst_vld_hold", 32'(vld1_o), 32'd0);
      i_rst_n = 1'b1;
      @(posedge i_clk); #1;
      run_div("c10_after_rst", 16'h0300, 16'h0200, 16'h0180, 1'b0, 1'b0, 25, 0);

      // R=4 instance: same answers, seven-edge latency.
      sel4 = 1'b1;
      #1;
      run_div("r4_c1", 16'h0300, 16'h0200, 16'h0180, 1'b0, 1'b0, 7, 0);
      run_div("r4_c2", 16'hFD00, 16'h0200, 16'hFE80, 1'b0, 1'b0, 7, 0);
      run_div("r4_c3", 16'h0100, 16'h0300, 16'h0055, 1'b0, 1'b0, 7, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
